// File: rtl/wb_index_unit_pkg.sv
// -----------------------------------------------------------------------------
// pkg_tpu : shared widths and types for the TPU lane write-back path.
//   index_t      : register-file destination index (WIDTH_INDEX bits)
//   mask_t       : per-element write-enable mask (WIDTH_MASK bits, power of 2)
//   data_t       : result beat payload (WIDTH_DATA bits)
//   wb_idx_st_t  : write-back index sequencer state
// -----------------------------------------------------------------------------
package pkg_tpu;

    localparam int unsigned WIDTH_INDEX = 8;
    localparam int unsigned WIDTH_MASK  = 8;
    localparam int unsigned WIDTH_DATA  = 16;
    localparam int unsigned MASK_SEL_W  = $clog2(WIDTH_MASK);

    typedef logic [WIDTH_INDEX-1:0] index_t;
    typedef logic [WIDTH_MASK-1:0]  mask_t;
    typedef logic [WIDTH_DATA-1:0]  data_t;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        RUN
    } wb_idx_st_t;

    // Mask bit for element c, i.e. bit (c mod WIDTH_MASK); WIDTH_MASK is a
    // power of two so the modulo is just the low bits of c.
    function automatic logic mask_bit(input mask_t m, input index_t c);
        logic [MASK_SEL_W-1:0] sel;
        sel = c[MASK_SEL_W-1:0];
        return m[sel];
    endfunction

endpackage

// File: rtl/wb_index_unit_if.sv
// -----------------------------------------------------------------------------
// wb_index_unit_if : configuration, result-beat and register-file write
// signals of the write-back index sequencer.
//   master : lane side (drives I_*, observes O_*)
//   slave  : wb_index_unit (observes I_*, drives O_*)
// -----------------------------------------------------------------------------
interface wb_index_unit_if;
    import pkg_tpu::*;

    logic   I_Stall;
    logic   I_Req;
    logic   I_Slice;
    index_t I_Base;
    index_t I_Window;
    index_t I_Stride;
    index_t I_Length;
    logic   I_MaskedWrite;
    mask_t  I_Mask;
    logic   I_Valid;
    data_t  I_Data;

    logic   O_Ack;
    logic   O_Busy;
    logic   O_We;
    index_t O_Index;
    data_t  O_Data;
    logic   O_Done;

    modport master (
        output I_Stall, I_Req, I_Slice, I_Base, I_Window, I_Stride, I_Length,
               I_MaskedWrite, I_Mask, I_Valid, I_Data,
        input  O_Ack, O_Busy, O_We, O_Index, O_Data, O_Done
    );

    modport slave (
        input  I_Stall, I_Req, I_Slice, I_Base, I_Window, I_Stride, I_Length,
               I_MaskedWrite, I_Mask, I_Valid, I_Data,
        output O_Ack, O_Busy, O_We, O_Index, O_Data, O_Done
    );

endinterface

// File: rtl/wb_index_unit_slice_cnt.sv
// -----------------------------------------------------------------------------
// wb_slice_cnt : element counter c, window offset w and row base r for the
// write-back sequencer. Destination index of the current element is r + w.
//   clock, reset : clock, synchronous active-high reset
//   clr_i        : c := 0, w := 0, r := base_i
//   en_i         : advance one element (wrap w at window_i, then r += stride_i)
//   c_o, w_o, r_o: current counter values
// -----------------------------------------------------------------------------
module wb_slice_cnt
    import pkg_tpu::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clr_i,
    input  logic   en_i,
    input  index_t base_i,
    input  index_t window_i,
    input  index_t stride_i,
    output index_t c_o,
    output index_t w_o,
    output index_t r_o
);

    index_t c_q, w_q, r_q;
    index_t c_d, w_d, r_d;

    always_comb begin
        c_d = c_q;
        w_d = w_q;
        r_d = r_q;
        if (clr_i) begin
            c_d = '0;
            w_d = '0;
            r_d = base_i;
        end else if (en_i) begin
            c_d = c_q + 1'b1;
            if (w_q == window_i) begin
                w_d = '0;
                r_d = r_q + stride_i;
            end else begin
                w_d = w_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_q <= '0;
            w_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            w_q <= w_d;
            r_q <= r_d;
        end
    end

    assign c_o = c_q;
    assign w_o = w_q;
    assign r_o = r_q;

endmodule

// File: rtl/wb_index_unit.sv
// -----------------------------------------------------------------------------
// wb_index_unit : write-back index sequencer for one TPU lane. Turns result
// beats into register-file write strobes with the destination index of each
// element; masked elements are consumed without a write.
//   LANE_ID : lane number (informational)
//   clock   : clock
//   reset   : synchronous, active-high reset
//   bus     : wb_index_unit_if.slave (config request, beats, write port)
// -----------------------------------------------------------------------------
module wb_index_unit
    import pkg_tpu::*;
#(
    parameter int unsigned LANE_ID = 0
)(
    input  logic            clock,
    input  logic            reset,
    wb_index_unit_if.slave  bus
);

    wb_idx_st_t state_q;

    index_t window_q, stride_q, length_q;
    logic   masked_q;
    mask_t  mask_q;

    logic   ack_q, busy_q, we_q, done_q;
    index_t index_q;
    data_t  data_q;

    index_t cnt_c, cnt_w, cnt_r;
    index_t cur_index;
    logic   accept, beat, wr_en, run_en;

    // Busy stays high through the done cycle, by which time the FSM is
    // already back in IDLE; gating on busy_q keeps that cycle non-accepting.
    assign accept    = (state_q == IDLE) && !busy_q && bus.I_Req && !bus.I_Stall;
    assign beat      = bus.I_Valid && !bus.I_Stall;
    assign run_en    = (state_q == RUN) && beat;
    assign cur_index = cnt_r + cnt_w;
    assign wr_en     = !masked_q || mask_bit(mask_q, cnt_c);

    wb_slice_cnt u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (accept),
        .en_i     (run_en),
        .base_i   (bus.I_Base),
        .window_i (window_q),
        .stride_i (stride_q),
        .c_o      (cnt_c),
        .w_o      (cnt_w),
        .r_o      (cnt_r)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            window_q <= '0;
            stride_q <= '0;
            length_q <= '0;
            masked_q <= 1'b0;
            mask_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= '0;
            data_q   <= '0;
        end else begin
            ack_q  <= accept;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        window_q <= bus.I_Window;
                        stride_q <= bus.I_Stride;
                        length_q <= bus.I_Length;
                        masked_q <= bus.I_MaskedWrite;
                        mask_q   <= bus.I_Mask;
                        state_q  <= bus.I_Slice ? RUN : SINGLE;
                    end
                end
                SINGLE: begin
                    if (beat) begin
                        we_q    <= wr_en;
                        index_q <= cur_index;
                        data_q  <= bus.I_Data;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (beat) begin
                        we_q    <= wr_en;
                        index_q <= cur_index;
                        data_q  <= bus.I_Data;
                        if (cnt_c == length_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.O_Ack   = ack_q;
    assign bus.O_Busy  = busy_q;
    assign bus.O_We    = we_q;
    assign bus.O_Index = index_q;
    assign bus.O_Data  = data_q;
    assign bus.O_Done  = done_q;

endmodule

// File: doc/wb_index_unit.md
# wb_index_unit

Write-back index sequencer for one TPU lane: the destination-side counterpart to the read-side index generator. It accepts a destination index configuration (base, window, stride, length, mask) and converts the stream of result beats leaving the lane pipeline into register-file write strobes with the matching destination index per element. Masked elements are consumed but not written. It sits between the lane execution pipeline output and the register-file write port.

## Interface
- LANE_ID, 0, lane number; informational only, no functional effect.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Stall  in  1  force stall; no request or beat accepted, counters frozen
- I_Req  in  1  new destination configuration valid
- I_Slice  in  1  1 = sliced (multi-element) write; 0 = single element at I_Base
- I_Base  in  index_t  first destination index
- I_Window  in  index_t  window size minus one (elements per row − 1)
- I_Stride  in  index_t  row-to-row index increment
- I_Length  in  index_t  total elements minus one
- I_MaskedWrite  in  1  enable masking with I_Mask
- I_Mask  in  mask_t  per-element write enable, bit (element mod WIDTH_MASK)
- I_Valid  in  1  result beat valid
- I_Data  in  data_t  result beat data
- O_Ack  out  1  configuration accepted (one-cycle pulse)
- O_Busy  out  1  sequence in progress
- O_We  out  1  register-file write enable
- O_Index  out  index_t  destination index for O_We
- O_Data  out  data_t  write data
- O_Done  out  1  last element written or skipped (one-cycle pulse)

## Operation
- FSM states: IDLE, SINGLE, RUN.
- IDLE: I_Req & ~I_Stall → latch Base, Window, Stride, Length, MaskedWrite, Mask; pulse O_Ack; go to RUN if I_Slice, else SINGLE. Clear element count c, window offset w, row base r := Base.
- SINGLE: first I_Valid & ~I_Stall writes Base (mask bit 0 applies when masked) → O_Done, IDLE.
- RUN: each I_Valid & ~I_Stall consumes element c at index r + w.
  - Write enable = ~MaskedWrite | Mask[c mod WIDTH_MASK].
  - If w == Window: w := 0, r := r + Stride; else w := w + 1.
  - If c == Length: O_Done, go to IDLE; else c := c + 1.
- I_Req while O_Busy is ignored (no O_Ack). I_Req on the cycle of the final beat is also ignored; it must be re-presented.
- I_Valid in IDLE is dropped (no write).
- Arithmetic: all index sums are modulo 2^WIDTH_INDEX and wrap silently. Window = 0 means every element advances by Stride. Length = 0 means a single element.

## Timing
- Reset values: O_Ack=0, O_Busy=0, O_We=0, O_Index=0, O_Data=0, O_Done=0; FSM=IDLE; c, w, r = 0.
- Reset mid-sequence aborts immediately. No O_Done is generated and no further writes occur.
- O_Ack is registered and asserted the cycle after acceptance. O_Busy is high from that cycle until the cycle O_Done is asserted, inclusive.
- O_We, O_Index, O_Data and O_Done are registered: latency 1 cycle from the accepting beat. O_Done is coincident with the final element's O_We, or with a skipped final element.
- A stalled cycle produces O_We=0 in the following cycle. O_Index and O_Data hold their last values.
- First beat is accepted no earlier than the cycle after configuration acceptance. The maximum rate is one element per cycle.

## Structure
- pkg_tpu provides index_t (WIDTH_INDEX), mask_t (WIDTH_MASK) and data_t.
- Add enum wb_idx_st_t {IDLE, SINGLE, RUN} to pkg_tpu.
- One sub-module, wb_slice_cnt, implements the c/w/r counter triple with clear, enable and wrap-on-window. The parent holds the FSM and the output registers.

## Test plan
- Single write: I_Req, I_Slice=0, Base=5, then one beat D=0xAA → O_We=1, O_Index=5, O_Data=0xAA and O_Done together, one cycle after the beat; O_Busy then drops.
- Sliced: Base=8, Window=1, Stride=4, Length=5, six consecutive beats → indices 8,9,12,13,16,17; O_Done with index 17.
- Masked: as the previous case with MaskedWrite=1, Mask=0b101010 → O_We only on indices 9,13,17. All six beats are consumed and O_Done is still on the 6th.
- Stall: stall for 2 cycles mid-sequence → no element lost or duplicated; O_We low for 2 cycles; the index sequence is unchanged.
- Wrap: Base=2^WIDTH_INDEX−1, Window=0, Stride=1, Length=2 → indices max, 0, 1.
- Protocol: I_Req while busy → no O_Ack. Reset asserted after the 3rd beat → all outputs 0 next cycle, no O_Done. A beat in IDLE → no write.
